control_config_botones: RTL
===========================

Name: control_config_botones

Overview:
- Upstream stage for the time/date field counters, including the day counter (field 6).
- Conditions raw board push-buttons and the configuration switch: 2-FF synchronisation, debounce, edge detection and auto-repeat.
- Outputs: the selected-field index `contadoresH` plus single-cycle `Arriba`/`Abajo` step pulses.
- Each field counter advances exactly once per pulse when its index is selected.

Parameters:
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz).
- `REPEAT_DELAY`, 50000000: hold time after the first step before auto-repeat starts (0.5 s).
- `REPEAT_PERIOD`, 26000000: cycles between auto-repeat pulses (~4 Hz).
- `NUM_CAMPOS`, 8: number of selectable fields; indices 1..NUM_CAMPOS, 6 = día.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `sw_config` in 1: raw switch; 1 = configuration mode.
- `btn_arriba` in 1: raw button, increment.
- `btn_abajo` in 1: raw button, decrement.
- `btn_izq` in 1: raw button, previous field.
- `btn_der` in 1: raw button, next field.
- `contadoresH` out 4: selected field; 0 = none.
- `Arriba` out 1: one-cycle increment pulse.
- `Abajo` out 1: one-cycle decrement pulse.
- `modo_config` out 1: debounced `sw_config`.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - All synchronisers, debounce counters, debounced levels and repeat counters cleared.
  - FSM = IDLE; `contadoresH`=0, `Arriba`=0, `Abajo`=0, `modo_config`=0.
  - Asserting reset mid-hold or mid-repeat aborts immediately with no trailing pulse.
- **Input conditioning (all five inputs):**
  - Each input passes through a 2-FF synchroniser.
  - The debounced level flips only after the synchronised value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any intermediate match clears that input's counter.
  - Rising edge of a debounced level = one-cycle internal press event, registered one cycle after the level changes.
- **Field selection:**
  - Rising edge of debounced `sw_config`: `contadoresH` <= 1.
  - Falling edge: `contadoresH` <= 0 and repeat FSM forced to IDLE.
  - While `modo_config`=1:
    - `btn_der` press: index+1, wrapping NUM_CAMPOS -> 1.
    - `btn_izq` press: index-1, wrapping 1 -> NUM_CAMPOS.
    - Simultaneous `btn_der` and `btn_izq` presses in the same cycle: index unchanged.
  - While `modo_config`=0: `btn_izq`/`btn_der` are ignored and `contadoresH` stays 0.
- **Step pulses:**
  - Produced only while `modo_config`=1 and `contadoresH`!=0.
  - Never both high in the same cycle; each is high for exactly 1 cycle per step.
- **Repeat FSM** (shared; `dir` register selects Arriba/Abajo):
  - IDLE:
    - Debounced `btn_arriba` rises with `btn_abajo` low: emit pulse, `dir`=up, go ESPERA.
    - Debounced `btn_abajo` rises with `btn_arriba` low: emit pulse, `dir`=down, go ESPERA.
    - Both high, or both rise together: no pulse, stay IDLE.
  - ESPERA:
    - Count `REPEAT_DELAY` cycles while the active button remains held.
    - On terminal count: emit pulse, clear counter, go REPITE.
  - REPITE: emit a pulse every `REPEAT_PERIOD` cycles while held.
  - ESPERA/REPITE exit to IDLE, with no pulse, if:
    - the active debounced button falls;
    - the opposite button's debounced level goes high;
    - `modo_config` falls; or
    - the field index changes.
  - Return to IDLE does not count as a new press; a new pulse needs a fresh rising edge.
- **Latency:** raw press stable from cycle 0 -> first pulse at cycle 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge register) + 1 (output register).
- **Registering:** all outputs are registered, with no combinational path from inputs.

Test Plan:
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
1. **Reset/idle:** reset low 3 cycles, then high, buttons idle -> all outputs 0.
   - Then `sw_config`=1 held -> `contadoresH`=1 after sync+debounce, `modo_config`=1.
2. **Field wrap:** in config mode, press `btn_der` 8 times -> sequence 2..8 then 1.
   - Then `btn_izq` once -> 8.
   - Bouncy `btn_der` (toggling every 2 cycles for 12 cycles, then stable) -> exactly one increment.
3. **Auto-repeat:** select field 6, hold `btn_arriba` 60 cycles after debounce -> `Arriba` pulses at relative cycles 0, 20, 28, 36, 44, 52; `Abajo` never asserted.
   - Release -> no further pulses.
4. **Conflicting buttons:** hold `btn_abajo` into REPITE, then press `btn_arriba` -> repeat stops, zero `Arriba` pulses.
   - Release both, press `btn_arriba` -> exactly one `Arriba`.
5. **Mode exit and ignored steps:** during REPITE drop `sw_config` -> `contadoresH`=0, no further pulses.
   - Press `btn_arriba` with `modo_config`=0 -> no pulse.
6. **Reset mid-operation:** assert reset during ESPERA -> outputs 0 within the same cycle and no pulse after release.
   - With `sw_config` still high: after release `contadoresH` returns to 1.

Source files
------------

// File: rtl/control_config_botones.sv
// Button and configuration-switch front end for the time/date field counters.
// Synchronises, debounces and edge-detects the raw board inputs. Tracks which
// field is selected and issues one-cycle Arriba/Abajo step pulses, with
// auto-repeat while a step button stays held.
module control_config_botones #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 26000000,
  parameter int NUM_CAMPOS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_config,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_izq,
  input  logic       btn_der,
  output logic [3:0] contadoresH,
  output logic       Arriba,
  output logic       Abajo,
  output logic       modo_config
);

  localparam int N_IN = 5;
  localparam int SW   = 0;
  localparam int UP   = 1;
  localparam int DN   = 2;
  localparam int IZQ  = 3;
  localparam int DER  = 4;

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic [3:0]    CAMPO_MAX  = 4'(NUM_CAMPOS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    REPITE = 2'd2
  } estado_t;

  logic [N_IN-1:0] w_raw;
  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] r_deb;
  logic [N_IN-1:0] r_deb_d;
  logic [N_IN-1:0] r_rise;
  logic [DW-1:0]   r_db_cnt [N_IN];

  logic [3:0]      r_idx;
  logic [3:0]      w_idx_next;
  logic            w_idx_chg;

  estado_t         r_estado;
  estado_t         w_estado_next;
  logic            r_dir;
  logic            w_dir_next;
  logic [RW-1:0]   r_rep_cnt;
  logic [RW-1:0]   w_rep_cnt_next;
  logic            w_up;
  logic            w_dn;
  logic            w_gate;
  logic            w_held;
  logic            w_opp;
  logic            w_abort;
  logic            r_arriba;
  logic            r_abajo;

  assign w_raw = {btn_der, btn_izq, btn_abajo, btn_arriba, sw_config};

  // Two-flop synchronisers followed by per-input debounce counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < N_IN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_IN; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_deb[i]    <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
          end
        end else begin
          // Any sample that agrees with the current level restarts the count.
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detection of the debounced levels (press events).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deb_d <= '0;
      r_rise  <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_rise  <= r_deb & ~r_deb_d;
    end
  end

  // Next selected field: entering config selects field 1, leaving clears it.
  always_comb begin
    w_idx_next = r_idx;
    if (r_rise[SW]) begin
      w_idx_next = 4'd1;
    end else if (!r_deb[SW]) begin
      w_idx_next = 4'd0;
    end else if (r_idx == 4'd0) begin
      // Config level is up but the entry event has not landed yet.
      w_idx_next = r_idx;
    end else if (r_rise[DER] && !r_rise[IZQ]) begin
      w_idx_next = (r_idx == CAMPO_MAX) ? 4'd1 : r_idx + 4'd1;
    end else if (r_rise[IZQ] && !r_rise[DER]) begin
      w_idx_next = (r_idx == 4'd1) ? CAMPO_MAX : r_idx - 4'd1;
    end else begin
      w_idx_next = r_idx;
    end
  end

  assign w_idx_chg = (w_idx_next != r_idx);

  // Repeat FSM next-state and step-pulse decode; dir=1 means Arriba.
  always_comb begin
    w_estado_next  = r_estado;
    w_dir_next     = r_dir;
    w_rep_cnt_next = r_rep_cnt;
    w_up           = 1'b0;
    w_dn           = 1'b0;
    w_gate         = r_deb[SW] && (r_idx != 4'd0);
    w_held         = r_dir ? r_deb[UP] : r_deb[DN];
    w_opp          = r_dir ? r_deb[DN] : r_deb[UP];
    w_abort        = !w_held || w_opp || !r_deb[SW] || w_idx_chg;
    case (r_estado)
      IDLE: begin
        if (w_gate && r_rise[UP] && !r_deb[DN]) begin
          w_up           = 1'b1;
          w_dir_next     = 1'b1;
          w_rep_cnt_next = '0;
          w_estado_next  = ESPERA;
        end else if (w_gate && r_rise[DN] && !r_deb[UP]) begin
          w_dn           = 1'b1;
          w_dir_next     = 1'b0;
          w_rep_cnt_next = '0;
          w_estado_next  = ESPERA;
        end else begin
          w_estado_next  = IDLE;
        end
      end
      ESPERA: begin
        if (w_abort) begin
          w_rep_cnt_next = '0;
          w_estado_next  = IDLE;
        end else if (r_rep_cnt == DELAY_LAST) begin
          w_up           = r_dir;
          w_dn           = !r_dir;
          w_rep_cnt_next = '0;
          w_estado_next  = REPITE;
        end else begin
          w_rep_cnt_next = r_rep_cnt + RW'(1);
        end
      end
      REPITE: begin
        if (w_abort) begin
          w_rep_cnt_next = '0;
          w_estado_next  = IDLE;
        end else if (r_rep_cnt == PER_LAST) begin
          w_up           = r_dir;
          w_dn           = !r_dir;
          w_rep_cnt_next = '0;
        end else begin
          w_rep_cnt_next = r_rep_cnt + RW'(1);
        end
      end
      default: begin
        w_rep_cnt_next = '0;
        w_estado_next  = IDLE;
      end
    endcase
  end

  // Repeat FSM state, direction and delay/period counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado  <= IDLE;
      r_dir     <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_estado  <= w_estado_next;
      r_dir     <= w_dir_next;
      r_rep_cnt <= w_rep_cnt_next;
    end
  end

  // Output registers: field index and step pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= 4'd0;
      r_arriba <= 1'b0;
      r_abajo  <= 1'b0;
    end else begin
      r_idx    <= w_idx_next;
      r_arriba <= w_up;
      r_abajo  <= w_dn;
    end
  end

  assign contadoresH = r_idx;
  assign Arriba      = r_arriba;
  assign Abajo       = r_abajo;
  assign modo_config = r_deb[SW];

endmodule
